// File: rtl/spi_cfg_pkg.sv
// Shared types, register map and reset values for the SPI configuration
// controller and its register file.
package spi_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        WAIT_END,
        ERR
    } state_t;

    localparam logic [3:0] ADDR_THR  = 4'h0;
    localparam logic [3:0] ADDR_FILT = 4'h1;
    localparam logic [3:0] ADDR_LED  = 4'h2;
    localparam logic [3:0] ADDR_ERR  = 4'h3;
    localparam logic [3:0] ADDR_ID   = 4'h4;

    localparam logic [7:0] THR_RST  = 8'd30;
    localparam logic [2:0] FILT_RST = 3'd4;
    localparam logic [1:0] LED_RST  = 2'd0;
    localparam logic [7:0] ID_VALUE = 8'hA5;
    localparam logic [7:0] FILT_MIN = 8'd2;
    localparam logic [7:0] FILT_MAX = 8'd7;

    // Read-only registers (err_count, ID) may not be targeted by a write.
    function automatic logic cmd_legal(input logic [7:0] cmd);
        return (cmd[6:4] == 3'b000) && (cmd[3:0] <= ADDR_ID)
            && !(cmd[7] && (cmd[3:0] >= ADDR_ERR));
    endfunction

    function automatic logic data_legal(input logic [3:0] addr,
                                        input logic [7:0] data);
        return (addr != ADDR_FILT)
            || ((data >= FILT_MIN) && (data <= FILT_MAX));
    endfunction

endpackage

// File: rtl/spi_cfg_regfile.sv
// Read/write configuration registers and the read-back multiplexer.
// Read-only sources (error counter, ID) are muxed in from outside.
module spi_cfg_regfile
    import spi_cfg_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    input  logic [7:0] err_count,
    output logic [7:0] rdata,
    output logic [7:0] threshold,
    output logic [2:0] filter_len,
    output logic [1:0] led_mode
);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            threshold  <= THR_RST;
            filter_len <= FILT_RST;
            led_mode   <= LED_RST;
        end else if (we) begin
            unique case (waddr)
                ADDR_THR:  threshold  <= wdata;
                ADDR_FILT: filter_len <= wdata[2:0];
                ADDR_LED:  led_mode   <= wdata[1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        unique case (raddr)
            ADDR_THR:  rdata = threshold;
            ADDR_FILT: rdata = {5'b0, filter_len};
            ADDR_LED:  rdata = {6'b0, led_mode};
            ADDR_ERR:  rdata = err_count;
            ADDR_ID:   rdata = ID_VALUE;
            default:   rdata = 8'h00;
        endcase
    end

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI configuration command decoder: two-byte command/data frames,
// staged writes committed at frame end, protocol error counting.
module spi_cfg_ctrl
    import spi_cfg_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic [7:0] cfg_threshold,
    output logic [2:0] cfg_filter_len,
    output logic [1:0] cfg_led_mode,
    output logic [7:0] err_count,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic       busy
);

    state_t     state;
    state_t     nstate;
    state_t     byte_st;
    logic       cmd_wr;
    logic [3:0] cmd_addr;
    logic [7:0] staged;
    logic [7:0] rdata;
    logic [7:0] wdata;
    logic       done;
    logic       err;
    logic       commit;
    logic       cmd_ld;
    logic       stage;
    logic       rd_ld;

    // A byte arriving with frame_end in DATA commits straight from rx_byte.
    assign wdata = (state == DATA) ? rx_byte : staged;
    assign busy  = (state != IDLE);

    spi_cfg_regfile u_regfile (
        .clk_in     (clk_in),
        .rst        (rst),
        .we         (commit),
        .waddr      (cmd_addr),
        .wdata      (wdata),
        .raddr      (rx_byte[3:0]),
        .err_count  (err_count),
        .rdata      (rdata),
        .threshold  (cfg_threshold),
        .filter_len (cfg_filter_len),
        .led_mode   (cfg_led_mode)
    );

    always_comb begin
        byte_st = state;
        nstate  = state;
        done    = 1'b0;
        err     = 1'b0;
        commit  = 1'b0;
        cmd_ld  = 1'b0;
        stage   = 1'b0;
        rd_ld   = 1'b0;

        // Byte handling first, then frame end against the resulting state.
        if (rx_valid) begin
            unique case (state)
                CMD: begin
                    if (cmd_legal(rx_byte)) begin
                        byte_st = DATA;
                        cmd_ld  = 1'b1;
                        rd_ld   = ~rx_byte[7];
                    end else begin
                        byte_st = ERR;
                    end
                end
                DATA: begin
                    if (!cmd_wr || data_legal(cmd_addr, rx_byte)) begin
                        byte_st = WAIT_END;
                        stage   = 1'b1;
                    end else begin
                        byte_st = ERR;
                    end
                end
                WAIT_END: byte_st = ERR;
                default: ;
            endcase
        end

        nstate = byte_st;

        if (frame_end) begin
            unique case (byte_st)
                CMD, DATA, ERR: begin
                    nstate = IDLE;
                    err    = 1'b1;
                end
                WAIT_END: begin
                    nstate = IDLE;
                    done   = 1'b1;
                    commit = cmd_wr;
                end
                default: ;
            endcase
        end

        // A new frame always wins; an unfinished one counts as an error.
        if (frame_start) begin
            nstate = CMD;
            done   = 1'b0;
            commit = 1'b0;
            cmd_ld = 1'b0;
            stage  = 1'b0;
            rd_ld  = 1'b0;
            err    = (state != IDLE);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= IDLE;
            cmd_wr    <= 1'b0;
            cmd_addr  <= 4'h0;
            staged    <= 8'h00;
            tx_byte   <= 8'h00;
            tx_load   <= 1'b0;
            err_count <= 8'h00;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state    <= nstate;
            tx_load  <= rd_ld;
            cmd_done <= done;
            cmd_err  <= err;
            if (cmd_ld) begin
                cmd_wr   <= rx_byte[7];
                cmd_addr <= rx_byte[3:0];
            end
            if (stage) staged <= rx_byte;
            if (rd_ld) tx_byte <= rdata;
            if (err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Table-driven bench for spi_cfg_ctrl with a scoreboard on the
// cmd_done/cmd_err and tx_load output pulses.
module tb_spi_cfg_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [7:0] cfg_threshold;
    logic [2:0] cfg_filter_len;
    logic [1:0] cfg_led_mode;
    logic [7:0] err_count;
    logic       cmd_done;
    logic       cmd_err;
    logic       busy;

    spi_cfg_ctrl dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .rx_valid       (rx_valid),
        .rx_byte        (rx_byte),
        .tx_byte        (tx_byte),
        .tx_load        (tx_load),
        .cfg_threshold  (cfg_threshold),
        .cfg_filter_len (cfg_filter_len),
        .cfg_led_mode   (cfg_led_mode),
        .err_count      (err_count),
        .cmd_done       (cmd_done),
        .cmd_err        (cmd_err),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int              nb;
        bit              same;
        logic [2:0][7:0] b;
        bit              done;
        bit              err;
        logic [7:0]      thr;
        logic [2:0]      flt;
        logic [1:0]      led;
        bit              txv;
        logic [7:0]      tx;
    } vec_t;

    typedef struct {
        bit         done;
        bit         err;
        logic [7:0] thr;
        logic [2:0] flt;
        logic [1:0] led;
        logic [7:0] ecnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_q[$];
    int         checks = 0;
    int         errors = 0;
    int         m_ecnt = 0;
    vec_t       tbl[0:19];
    exp_t       mon_e;
    logic [7:0] mon_tx;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input int nb, input bit same,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input bit done,
                                input bit err, input logic [7:0] thr,
                                input logic [2:0] flt, input logic [1:0] led,
                                input bit txv, input logic [7:0] tx);
        vec_t v;
        v.nb = nb; v.same = same; v.b = {b2, b1, b0};
        v.done = done; v.err = err; v.thr = thr; v.flt = flt;
        v.led = led; v.txv = txv; v.tx = tx;
        return v;
    endfunction

    always @(negedge clk_in) begin
        if (cmd_done || cmd_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'b0, cmd_done, cmd_err}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("cmd_done", cmd_done, mon_e.done);
                chk("cmd_err", cmd_err, mon_e.err);
                chk("threshold", cfg_threshold, mon_e.thr);
                chk("filter_len", cfg_filter_len, mon_e.flt);
                chk("led_mode", cfg_led_mode, mon_e.led);
                chk("err_count", err_count, mon_e.ecnt);
            end
        end
        if (tx_load) begin
            if (tx_q.size() == 0) begin
                chk("unexpected_tx_load", tx_load, 0);
            end else begin
                mon_tx = tx_q.pop_front();
                chk("tx_byte", tx_byte, mon_tx);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input bit done, input bit err,
                            input logic [7:0] thr, input logic [2:0] flt,
                            input logic [1:0] led);
        exp_t e;
        if (err && m_ecnt < 255) m_ecnt++;
        e.done = done; e.err = err; e.thr = thr; e.flt = flt;
        e.led = led; e.ecnt = m_ecnt[7:0];
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    endtask

    task automatic pulse_end();
        frame_end = 1'b1; tick(); frame_end = 1'b0; tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() + tx_q.size()) != 0 && n < 8) begin
            tick();
            n++;
        end
        chk("drain_timeout", exp_q.size() + tx_q.size(), 0);
        exp_q.delete();
        tx_q.delete();
    endtask

    task automatic run_frame(input vec_t v);
        pulse_start();
        chk("busy_in_frame", busy, 1);
        for (int i = 0; i < v.nb; i++) begin
            rx_byte = v.b[i];
            rx_valid = 1'b1;
            if (i == 0 && v.txv) tx_q.push_back(v.tx);
            if (i == v.nb - 1 && v.same) begin
                push_exp(v.done, v.err, v.thr, v.flt, v.led);
                frame_end = 1'b1;
            end
            tick();
            rx_valid = 1'b0;
            frame_end = 1'b0;
            tick();
        end
        if (!v.same) begin
            push_exp(v.done, v.err, v.thr, v.flt, v.led);
            pulse_end();
        end
        drain();
        chk("busy_after_frame", busy, 0);
    endtask

    initial begin
        tbl[0]  = mk(3, 0, 8'h80, 8'h10, 8'h22, 0, 1, 8'h1E, 3'd4, 2'd0, 0, 8'h00);
        tbl[1]  = mk(2, 0, 8'h80, 8'h40, 8'h00, 1, 0, 8'h40, 3'd4, 2'd0, 0, 8'h00);
        tbl[2]  = mk(2, 0, 8'h04, 8'h00, 8'h00, 1, 0, 8'h40, 3'd4, 2'd0, 1, 8'hA5);
        tbl[3]  = mk(2, 0, 8'h81, 8'h09, 8'h00, 0, 1, 8'h40, 3'd4, 2'd0, 0, 8'h00);
        tbl[4]  = mk(2, 0, 8'h81, 8'h07, 8'h00, 1, 0, 8'h40, 3'd7, 2'd0, 0, 8'h00);
        tbl[5]  = mk(2, 0, 8'h01, 8'h00, 8'h00, 1, 0, 8'h40, 3'd7, 2'd0, 1, 8'h07);
        tbl[6]  = mk(2, 0, 8'h82, 8'hFE, 8'h00, 1, 0, 8'h40, 3'd7, 2'd2, 0, 8'h00);
        tbl[7]  = mk(2, 0, 8'h81, 8'h02, 8'h00, 1, 0, 8'h40, 3'd2, 2'd2, 0, 8'h00);
        tbl[8]  = mk(2, 0, 8'h81, 8'h01, 8'h00, 0, 1, 8'h40, 3'd2, 2'd2, 0, 8'h00);
        tbl[9]  = mk(2, 0, 8'h90, 8'h00, 8'h00, 0, 1, 8'h40, 3'd2, 2'd2, 0, 8'h00);
        tbl[10] = mk(2, 0, 8'h05, 8'h00, 8'h00, 0, 1, 8'h40, 3'd2, 2'd2, 0, 8'h00);
        tbl[11] = mk(2, 0, 8'h84, 8'h11, 8'h00, 0, 1, 8'h40, 3'd2, 2'd2, 0, 8'h00);
        tbl[12] = mk(2, 0, 8'h83, 8'h11, 8'h00, 0, 1, 8'h40, 3'd2, 2'd2, 0, 8'h00);
        tbl[13] = mk(2, 0, 8'h03, 8'h00, 8'h00, 1, 0, 8'h40, 3'd2, 2'd2, 1, 8'h06);
        tbl[14] = mk(1, 0, 8'h80, 8'h00, 8'h00, 0, 1, 8'h40, 3'd2, 2'd2, 0, 8'h00);
        tbl[15] = mk(2, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h40, 3'd2, 2'd2, 1, 8'h40);
        tbl[16] = mk(2, 1, 8'h80, 8'h77, 8'h00, 1, 0, 8'h77, 3'd2, 2'd2, 0, 8'h00);
        tbl[17] = mk(1, 1, 8'h80, 8'h00, 8'h00, 0, 1, 8'h77, 3'd2, 2'd2, 0, 8'h00);
        tbl[18] = mk(3, 1, 8'h80, 8'h10, 8'h22, 0, 1, 8'h77, 3'd2, 2'd2, 0, 8'h00);
        tbl[19] = mk(2, 0, 8'h02, 8'h00, 8'h00, 1, 0, 8'h77, 3'd2, 2'd2, 1, 8'h02);

        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_threshold", cfg_threshold, 8'h1E);
        chk("rst_filter_len", cfg_filter_len, 3'd4);
        chk("rst_led_mode", cfg_led_mode, 2'd0);
        chk("rst_err_count", err_count, 8'h00);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_pulses", {tx_load, cmd_done, cmd_err}, 0);
        rst = 1'b0;
        tick();

        // Bytes and frame end in IDLE are ignored.
        send(8'h80);
        pulse_end();
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_threshold", cfg_threshold, 8'h1E);

        run_frame(tbl[0]);

        // Mid-frame reset discards the staged write.
        pulse_start();
        send(8'h80);
        send(8'h55);
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_threshold", cfg_threshold, 8'h1E);
        chk("midrst_err_count", err_count, 8'h00);
        rst = 1'b0;
        m_ecnt = 0;
        tick();
        send(8'h81);
        send(8'h07);
        pulse_end();
        tick(); tick();
        chk("postrst_filter_len", cfg_filter_len, 3'd4);
        chk("postrst_busy", busy, 0);

        for (int i = 1; i < 20; i++) run_frame(tbl[i]);

        // A new frame_start aborts a pending write, then runs normally.
        pulse_start();
        send(8'h80);
        send(8'h55);
        push_exp(0, 1, 8'h77, 3'd2, 2'd2);
        pulse_start();
        tx_q.push_back(8'h77);
        send(8'h00);
        send(8'h00);
        push_exp(1, 0, 8'h77, 3'd2, 2'd2);
        pulse_end();
        drain();

        for (int i = 0; i < 300; i++)
            run_frame(mk(0, 0, 8'h00, 8'h00, 8'h00, 0, 1,
                         8'h77, 3'd2, 2'd2, 0, 8'h00));
        chk("sat_err_count", err_count, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
